irq_source_gateway: RTL and testbench
=====================================

Name: irq_source_gateway

Overview:
- Per-source interrupt conditioner for one external interrupt line.
- Synchronizes the asynchronous pin, glitch-filters it, and runs a one-outstanding-request gateway: level or edge mode, with claim/complete handshake.
- `io_out` feeds the single-bit fanout stage that distributes the request to the interrupt controller and the debug observation path.

Parameters:
- SYNC_STAGES, 3, flops in the input synchronizer chain; legal range 2..4.
- FILTER_CYCLES, 4, consecutive stable cycles required before the filtered value changes; 0 bypasses the filter.
- EDGE_CNT_W, 2, width of the saturating pending-edge counter used in edge mode.

Ports:
- clock  input  1  block clock.
- reset  input  1  synchronous, active-low reset.
- io_in  input  1  raw asynchronous interrupt pin, active-high.
- io_cfg_edge  input  1  mode select: 1 = edge (rising) mode, 0 = level mode. Quasi-static.
- io_claim  input  1  single-cycle pulse: controller has taken the request.
- io_complete  input  1  single-cycle pulse: handler has finished.
- io_out  output  1  request level to the fanout stage.
- io_filtered  output  1  filtered pin value, for debug.
- io_edge_cnt  output  EDGE_CNT_W  queued edges not yet presented.

Behaviour:
- Reset (reset==0 at a clock edge) clears all state, regardless of current state:
  - sync chain = 0, filter counter = 0, filtered = 0, edge counter = 0, state = IDLE.
  - io_out = 0, io_filtered = 0, io_edge_cnt = 0.
- Synchronizer: io_in passes through SYNC_STAGES flops; sync = last stage.
- Filter:
  - When sync != filtered, the counter increments; when sync == filtered, the counter clears.
  - When the counter reaches FILTER_CYCLES-1 and sync still differs, filtered takes sync and the counter clears.
  - FILTER_CYCLES=0: filtered = sync, registered with one cycle of delay.
  - Pulses shorter than FILTER_CYCLES cycles at sync are dropped.
- Latency, pin rise to io_filtered rise: SYNC_STAGES + FILTER_CYCLES cycles (3+4=7 at defaults).
- Edge detect: rise = filtered & ~filtered_q; evaluated only when io_cfg_edge=1.
- Edge counter:
  - Increments on rise and saturates at 2^EDGE_CNT_W-1.
  - Decrements when IDLE->PENDING is taken in edge mode.
  - Rise and decrement in the same cycle leave it unchanged.
  - Any change of io_cfg_edge clears it on the following cycle.
- Gateway FSM (states IDLE, PENDING, INFLIGHT):
  - IDLE -> PENDING when level mode with filtered=1, or edge mode with edge counter != 0, or edge mode with rise this cycle.
  - PENDING -> INFLIGHT on io_claim.
  - INFLIGHT -> IDLE on io_complete.
- io_out is registered and equals (state == PENDING). It rises 1 cycle after the IDLE->PENDING condition is true and falls the cycle after claim.
- Handshake rules:
  - io_claim outside PENDING is ignored.
  - io_complete outside INFLIGHT is ignored.
  - io_claim and io_complete together in PENDING: claim taken, complete ignored, so state stays INFLIGHT.
  - Complete and a re-request in the same INFLIGHT cycle: state goes to IDLE, and the PENDING re-evaluation happens next cycle (minimum 1 IDLE cycle between requests).
- Level mode: the source deasserting while PENDING does not withdraw io_out; the request is held until claim.
- Edge mode: edges arriving in PENDING or INFLIGHT are queued in the counter (up to saturation); each queued edge produces one later request.

Test Plan:
- Reset: hold reset=0 for 2 cycles with io_in=1 -> io_out=0, io_filtered=0, io_edge_cnt=0. After release with io_in held at 1, io_filtered=1 at cycle 7 and io_out=1 at cycle 8.
- Glitch rejection: defaults, io_in high for 3 cycles then low -> io_filtered never rises, io_out stays 0. Repeat with 4-cycle pulse -> io_filtered pulses high for 4 cycles, and io_out rises in level mode.
- Level handshake:
  - Request with io_in held 1.
  - Claim -> io_out=0 next cycle.
  - Complete -> io_out=1 again 2 cycles after complete, since the source is still high.
  - Drop io_in before claim -> io_out held at 1 until claim.
- Edge queueing: io_cfg_edge=1, three clean rising edges while INFLIGHT -> io_edge_cnt=3. Four edges -> still 3 (saturation). Then three complete/claim rounds each yield exactly one io_out pulse, and the count ends at 0.
- Simultaneous events:
  - Claim+complete in PENDING -> state INFLIGHT, io_out=0.
  - Complete in IDLE -> no effect.
  - Rise in the same cycle as an IDLE->PENDING decrement -> count unchanged.
- Reset mid-operation: assert reset while INFLIGHT with io_edge_cnt=2 -> next cycle all outputs 0. After release, no stale request appears unless the pin is high (level mode) or a new edge is seen (edge mode).

Source files
------------

// File: rtl/irq_source_gateway.sv
// Per-source interrupt conditioner: pin synchronizer, glitch filter, and a
// one-outstanding-request gateway (level or rising-edge mode) with claim/complete.
module irq_source_gateway #(
  parameter int SYNC_STAGES   = 3,  // legal range 2..4
  parameter int FILTER_CYCLES = 4,  // 0 bypasses the filter
  parameter int EDGE_CNT_W    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in,
  input  logic                  io_cfg_edge,
  input  logic                  io_claim,
  input  logic                  io_complete,
  output logic                  io_out,
  output logic                  io_filtered,
  output logic [EDGE_CNT_W-1:0] io_edge_cnt,
  output logic [1:0]            io_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_INFLIGHT = 2'd2
  } gw_state_e;

  localparam logic [EDGE_CNT_W-1:0] ECNT_MAX = {EDGE_CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q;
  logic                   cfg_q;
  logic [EDGE_CNT_W-1:0]  ecnt_q, ecnt_d;
  gw_state_e              state_q, state_d;
  logic                   out_q, out_d;
  logic                   rise;
  logic                   idle_req;
  logic                   edge_dec;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], io_in};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // Filtered value only moves after sync has disagreed for FILTER_CYCLES cycles.
  if (FILTER_CYCLES == 0) begin : g_bypass
    assign filt_d = sync;
  end else begin : g_filter
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync != filt_q) begin
        if (cnt_q == LAST) filt_d = sync;
        else               cnt_d  = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      cfg_q       <= 1'b0;
      ecnt_q      <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cfg_q       <= io_cfg_edge;
      ecnt_q      <= ecnt_d;
    end
  end

  assign rise     = io_cfg_edge & filt_q & ~filt_prev_q;
  assign idle_req = io_cfg_edge ? ((ecnt_q != '0) | rise) : filt_q;

  // A rise that is consumed directly by a new request never enters the queue.
  always_comb begin
    ecnt_d = ecnt_q;
    if (io_cfg_edge != cfg_q) begin
      ecnt_d = '0;
    end else if (rise && !edge_dec) begin
      if (ecnt_q != ECNT_MAX) ecnt_d = ecnt_q + 1'b1;
    end else if (!rise && edge_dec) begin
      ecnt_d = ecnt_q - 1'b1;
    end
  end

  // Handshake: io_claim is a one-cycle pulse honoured only in PENDING;
  // io_complete is a one-cycle pulse honoured only in INFLIGHT.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (idle_req)    state_d = ST_PENDING;
      ST_PENDING:  if (io_claim)    state_d = ST_INFLIGHT;
      ST_INFLIGHT: if (io_complete) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d    = (state_d == ST_PENDING);
    edge_dec = (state_q == ST_IDLE) && (state_d == ST_PENDING) && io_cfg_edge;
  end

  assign io_out       = out_q;
  assign io_filtered  = filt_q;
  assign io_edge_cnt  = ecnt_q;
  assign io_dbg_state = state_q;

endmodule

// File: tb/tb_irq_source_gateway.sv
// Directed bench for irq_source_gateway at default parameters.
module tb_irq_source_gateway;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PENDING  = 2'd1;
  localparam logic [1:0] S_INFLIGHT = 2'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in;
  logic       io_cfg_edge;
  logic       io_claim;
  logic       io_complete;
  logic       io_out;
  logic       io_filtered;
  logic [1:0] io_edge_cnt;
  logic [1:0] io_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  irq_source_gateway dut (
    .clock       (clock),
    .reset       (reset),
    .io_in       (io_in),
    .io_cfg_edge (io_cfg_edge),
    .io_claim    (io_claim),
    .io_complete (io_complete),
    .io_out      (io_out),
    .io_filtered (io_filtered),
    .io_edge_cnt (io_edge_cnt),
    .io_dbg_state(io_dbg_state)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_claim();
    io_claim = 1'b1;
    step();
    io_claim = 1'b0;
  endtask

  task automatic pulse_complete();
    io_complete = 1'b1;
    step();
    io_complete = 1'b0;
  endtask

  task automatic pin_pulse(input int hi, input int lo);
    io_in = 1'b1;
    step(hi);
    io_in = 1'b0;
    step(lo);
  endtask

  task automatic test_reset();
    io_in = 1'b1; io_cfg_edge = 1'b0; io_claim = 1'b0; io_complete = 1'b0;
    reset = 1'b0;
    step(2);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", io_out); end
    n_tests++; if (io_filtered !== 1'b0) begin n_fail++; $display("FAIL reset_filtered: got %b expected 0", io_filtered); end
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", io_edge_cnt); end
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
    reset = 1'b1;
    step(6);
    n_tests++; if (io_filtered !== 1'b0) begin n_fail++; $display("FAIL latency_filt_c6: got %b expected 0", io_filtered); end
    step();
    n_tests++; if (io_filtered !== 1'b1) begin n_fail++; $display("FAIL latency_filt_c7: got %b expected 1", io_filtered); end
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL latency_out_c7: got %b expected 0", io_out); end
    step();
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL latency_out_c8: got %b expected 1", io_out); end
    n_tests++; if (io_dbg_state !== S_PENDING) begin n_fail++; $display("FAIL latency_state_c8: got %0d expected %0d", io_dbg_state, S_PENDING); end
  endtask

  task automatic test_level_handshake();
    pulse_claim();
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL lvl_claim_out: got %b expected 0", io_out); end
    n_tests++; if (io_dbg_state !== S_INFLIGHT) begin n_fail++; $display("FAIL lvl_claim_state: got %0d expected %0d", io_dbg_state, S_INFLIGHT); end
    step(3);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL lvl_inflight_out: got %b expected 0", io_out); end
    pulse_complete();
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL lvl_cpl_out_c1: got %b expected 0", io_out); end
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL lvl_cpl_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
    step();
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL lvl_rereq_out_c2: got %b expected 1", io_out); end
    io_in = 1'b0;
    step(12);
    n_tests++; if (io_filtered !== 1'b0) begin n_fail++; $display("FAIL lvl_drop_filt: got %b expected 0", io_filtered); end
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL lvl_drop_held: got %b expected 1", io_out); end
    pulse_claim();
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL lvl_drop_claim: got %b expected 0", io_out); end
    pulse_complete();
    step(3);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL lvl_drop_idle_out: got %b expected 0", io_out); end
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL lvl_drop_idle_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
  endtask

  task automatic test_glitch();
    logic seen_filt, seen_out;
    int   hi_cycles;
    seen_filt = 1'b0; seen_out = 1'b0; hi_cycles = 0;
    io_in = 1'b1;
    step(3);
    io_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen_filt |= io_filtered;
      seen_out  |= io_out;
    end
    n_tests++; if (seen_filt !== 1'b0) begin n_fail++; $display("FAIL glitch3_filt: got %b expected 0", seen_filt); end
    n_tests++; if (seen_out !== 1'b0) begin n_fail++; $display("FAIL glitch3_out: got %b expected 0", seen_out); end
    io_in = 1'b1;
    step(4);
    io_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (io_filtered === 1'b1) hi_cycles++;
    end
    n_tests++; if (hi_cycles !== 4) begin n_fail++; $display("FAIL glitch4_width: got %0d expected 4", hi_cycles); end
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL glitch4_out: got %b expected 1", io_out); end
    pulse_claim();
    pulse_complete();
    step(2);
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL glitch4_cleanup: got %0d expected %0d", io_dbg_state, S_IDLE); end
  endtask

  task automatic test_handshake_corners();
    pulse_complete();
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL cpl_in_idle: got %0d expected %0d", io_dbg_state, S_IDLE); end
    pulse_claim();
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL claim_in_idle: got %0d expected %0d", io_dbg_state, S_IDLE); end
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL idle_out: got %b expected 0", io_out); end
    io_in = 1'b1;
    step(8);
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL corner_req: got %b expected 1", io_out); end
    io_claim = 1'b1; io_complete = 1'b1;
    step();
    io_claim = 1'b0; io_complete = 1'b0;
    n_tests++; if (io_dbg_state !== S_INFLIGHT) begin n_fail++; $display("FAIL claim_cpl_state: got %0d expected %0d", io_dbg_state, S_INFLIGHT); end
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL claim_cpl_out: got %b expected 0", io_out); end
    pulse_claim();
    step(2);
    n_tests++; if (io_dbg_state !== S_INFLIGHT) begin n_fail++; $display("FAIL claim_in_inflight: got %0d expected %0d", io_dbg_state, S_INFLIGHT); end
    io_in = 1'b0;
    step(12);
    pulse_complete();
    step(2);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL corner_cleanup_out: got %b expected 0", io_out); end
  endtask

  task automatic test_edge_queue();
    io_cfg_edge = 1'b1;
    step(2);
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL edge_start_cnt: got %0d expected 0", io_edge_cnt); end
    pin_pulse(8, 10);
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL edge_first_req: got %b expected 1", io_out); end
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL edge_first_cnt: got %0d expected 0", io_edge_cnt); end
    pulse_claim();
    for (int i = 0; i < 3; i++) pin_pulse(8, 10);
    n_tests++; if (io_edge_cnt !== 2'd3) begin n_fail++; $display("FAIL edge_queue3: got %0d expected 3", io_edge_cnt); end
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL edge_queue_out: got %b expected 0", io_out); end
    pin_pulse(8, 10);
    n_tests++; if (io_edge_cnt !== 2'd3) begin n_fail++; $display("FAIL edge_saturate: got %0d expected 3", io_edge_cnt); end
    for (int r = 0; r < 3; r++) begin
      pulse_complete();
      n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL edge_round%0d_gap: got %b expected 0", r, io_out); end
      step();
      n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL edge_round%0d_out: got %b expected 1", r, io_out); end
      n_tests++; if (io_edge_cnt !== 2'(2 - r)) begin n_fail++; $display("FAIL edge_round%0d_cnt: got %0d expected %0d", r, io_edge_cnt, 2 - r); end
      pulse_claim();
    end
    pulse_complete();
    step(3);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL edge_drained_out: got %b expected 0", io_out); end
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL edge_drained_cnt: got %0d expected 0", io_edge_cnt); end
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL edge_drained_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
  endtask

  task automatic test_rise_with_decrement();
    pin_pulse(8, 10);
    pulse_claim();
    pin_pulse(8, 10);
    n_tests++; if (io_edge_cnt !== 2'd1) begin n_fail++; $display("FAIL rd_setup_cnt: got %0d expected 1", io_edge_cnt); end
    io_in = 1'b1;
    step(6);
    io_complete = 1'b1;
    step();
    io_complete = 1'b0;
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rd_idle_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
    n_tests++; if (io_filtered !== 1'b1) begin n_fail++; $display("FAIL rd_rise_filt: got %b expected 1", io_filtered); end
    step();
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL rd_req_out: got %b expected 1", io_out); end
    n_tests++; if (io_edge_cnt !== 2'd1) begin n_fail++; $display("FAIL rd_cnt_unchanged: got %0d expected 1", io_edge_cnt); end
    io_in = 1'b0;
    step(10);
  endtask

  task automatic test_reset_midop();
    pulse_claim();
    pin_pulse(8, 10);
    n_tests++; if (io_edge_cnt !== 2'd2) begin n_fail++; $display("FAIL mid_setup_cnt: got %0d expected 2", io_edge_cnt); end
    n_tests++; if (io_dbg_state !== S_INFLIGHT) begin n_fail++; $display("FAIL mid_setup_state: got %0d expected %0d", io_dbg_state, S_INFLIGHT); end
    reset = 1'b0;
    step();
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got %b expected 0", io_out); end
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d expected 0", io_edge_cnt); end
    n_tests++; if (io_dbg_state !== S_IDLE) begin n_fail++; $display("FAIL mid_rst_state: got %0d expected %0d", io_dbg_state, S_IDLE); end
    reset = 1'b1;
    step(12);
    n_tests++; if (io_out !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale_out: got %b expected 0", io_out); end
    n_tests++; if (io_edge_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_no_stale_cnt: got %0d expected 0", io_edge_cnt); end
    pin_pulse(8, 2);
    n_tests++; if (io_out !== 1'b1) begin n_fail++; $display("FAIL mid_new_edge_out: got %b expected 1", io_out); end
  endtask

  initial begin
    test_reset();
    test_level_handshake();
    test_glitch();
    test_handshake_corners();
    test_edge_queue();
    test_rise_with_decrement();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
